// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the unified-memory initiator: FSM state encoding,
// word-index constants and the request-to-response latencies (counted in
// cycles after the accept edge, i.e. the first RESP cycle is cycle N).
package mem_init_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic WORD0 = 1'b0;
    localparam logic WORD1 = 1'b1;

    localparam int LAT_LOAD     = 3;
    localparam int LAT_LOAD_DW  = 5;
    localparam int LAT_STORE    = 2;
    localparam int LAT_STORE_DW = 3;
    localparam int LAT_FAULT    = 1;

endpackage

// File: rtl/mem_initiator_if.sv
// Core-side request/response handshake bundle for the memory initiator.
// master = the core issuing requests, slave = the initiator serving them.
interface mem_initiator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic                      req_dword;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [2*DATA_WIDTH-1:0]   req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [2*DATA_WIDTH-1:0]   rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_we, req_dword, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_dword, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_initiator.sv
// Bus-side initiator for the single-port unified memory. Sequences one or two
// word loads/stores against a memory that registers its address on posedge and
// drives read data on negedge, then holds the response until the core takes it.
// Optional feature macro: MEM_INIT_BOUNDS_EN (address range check against
// ADDR_LIMIT; faulting requests skip memory and answer with rsp_err=1).
module mem_initiator
    import mem_init_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_initiator_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_w,
    output logic                  mem_r,
    input  logic [DATA_WIDTH-1:0] mem_q
);

`ifdef MEM_INIT_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  state_q, state_d;
    logic                    idx_q, idx_d;
    logic                    we_q, we_d;
    logic                    dword_q, dword_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic                    mem_w_q, mem_w_d;
    logic                    mem_r_q, mem_r_d;

    logic [ADDR_WIDTH-1:0]   req_addr_p1;
    logic                    req_fault;

    // Second word of a dword wraps modulo 2**ADDR_WIDTH; a wrap to 0 is in range.
    assign req_addr_p1 = bus.req_addr + ADDR_ONE;
    assign req_fault   = BOUNDS_EN &&
                         ((bus.req_addr > ADDR_LIMIT) ||
                          (bus.req_dword && (req_addr_p1 > ADDR_LIMIT)));

    // State register plus all latched request/response/memory-drive registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= WORD0;
            we_q       <= 1'b0;
            dword_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_w_q    <= 1'b0;
            mem_r_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            dword_q    <= dword_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_w_q    <= mem_w_d;
            mem_r_q    <= mem_r_d;
        end
    end

    // Next-state logic; memory strobes are computed for the state being entered
    // so they are registered and glitch-free during that state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we_d       = we_q;
        dword_d    = dword_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_w_d    = 1'b0;
        mem_r_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    dword_d = bus.req_dword;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    idx_d   = WORD0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (req_fault) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (bus.req_we) begin
                        mem_w_d    = 1'b1;
                        mem_addr_d = bus.req_addr;
                        mem_data_d = bus.req_wdata[DATA_WIDTH-1:0];
                        state_d    = S_WR;
                    end else begin
                        mem_r_d    = 1'b1;
                        mem_addr_d = bus.req_addr;
                        state_d    = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                mem_r_d = 1'b1;
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (idx_q == WORD1) begin
                    rdata_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_q;
                end else begin
                    rdata_d[DATA_WIDTH-1:0] = mem_q;
                end
                if (dword_q && (idx_q == WORD0)) begin
                    idx_d      = WORD1;
                    mem_r_d    = 1'b1;
                    mem_addr_d = addr_q + ADDR_ONE;
                    state_d    = S_RD_ADDR;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                if (dword_q && (idx_q == WORD0)) begin
                    idx_d      = WORD1;
                    mem_w_d    = 1'b1;
                    mem_addr_d = addr_q + ADDR_ONE;
                    mem_data_d = wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = BOUNDS_EN ? err_q : 1'b0;

    // A store word must not reach memory on an edge where reset is asserted.
    assign mem_w    = mem_w_q & ~rst;
    assign mem_r    = mem_r_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

    // we_q is only needed to remember the request kind across the sequence.
    logic unused_we;
    assign unused_we = we_q;

endmodule
